// File: rtl/ft2232h_pkg.sv
// ----------------------------------------------------------------------------
// ft2232h_pkg
// Definitions shared by the FT2232H transmit path:
//   BYTE_W             - width of one transfer byte
//   DEPTH_DEF          - default FIFO storage depth (entries)
//   FLUSH_LEVEL_DEF    - default occupancy that releases a burst in flush mode
//   FLUSH_TIMEOUT_DEF  - default idle cycles before a partial burst is released
//   flush_state_t      - HOLD/DRAIN encoding of the flush controller
//   idle_cnt_w()       - width needed to hold an idle count up to a timeout
// ----------------------------------------------------------------------------
package ft2232h_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEPTH_DEF         = 16;
  localparam int FLUSH_LEVEL_DEF   = 8;
  localparam int FLUSH_TIMEOUT_DEF = 64;

  typedef enum logic [0:0] {
    ST_HOLD  = 1'b0,
    ST_DRAIN = 1'b1
  } flush_state_t;

  // Bits required to represent values 0..timeout inclusive.
  function automatic int idle_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/tx_flush_ctrl.sv
// ----------------------------------------------------------------------------
// tx_flush_ctrl
// Burst-release controller for tx_byte_fifo. Holds bytes back (HOLD) until
// either enough bytes are queued or the upstream has gone quiet for long
// enough, then lets the FIFO drain (DRAIN) until it is empty.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset (state -> HOLD)
//   i_count      in   FIFO occupancy this cycle
//   i_count_next in   FIFO occupancy after this clock edge
//   i_wr_en      in   a byte is written into the FIFO on this edge
//   o_drain      out  1 while the FIFO is allowed to present data
// ----------------------------------------------------------------------------
module tx_flush_ctrl
  import ft2232h_pkg::*;
#(
  parameter int CW            = 5,
  parameter int FLUSH_LEVEL   = FLUSH_LEVEL_DEF,
  parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] i_count,
  input  logic [CW-1:0] i_count_next,
  input  logic          i_wr_en,
  output logic          o_drain
);

  localparam int            IW       = idle_cnt_w(FLUSH_TIMEOUT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_TIMEOUT);
  localparam logic [CW-1:0] LEVEL    = CW'(FLUSH_LEVEL);

  flush_state_t  r_state;
  flush_state_t  w_state_next;
  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_next;

  // Idle counter: only meaningful in HOLD; any write or an empty FIFO
  // restarts it, and it sticks at the timeout value.
  always_comb begin
    w_idle_next = r_idle;
    if (r_state == ST_DRAIN) begin
      w_idle_next = '0;
    end else if (i_wr_en || (i_count == '0)) begin
      w_idle_next = '0;
    end else if (r_idle != IDLE_MAX) begin
      w_idle_next = r_idle + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_idle_next;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Decisions look at the post-edge occupancy and idle
  // count so the release happens on the same edge that crosses a threshold,
  // and the return to HOLD happens on the edge the FIFO empties.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HOLD: begin
        if ((i_count_next >= LEVEL) || (w_idle_next == IDLE_MAX)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_count_next == '0) begin
          w_state_next = ST_HOLD;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_drain = 1'b0;
    if (r_state == ST_DRAIN) begin
      o_drain = 1'b1;
    end
  end

endmodule

// File: rtl/tx_byte_fifo.sv
// ----------------------------------------------------------------------------
// tx_byte_fifo
// First-word-fall-through byte FIFO feeding the FT2232H TX engine.
// Optional flush mode (macro TX_FIFO_FLUSH_EN) holds data back until a burst
// level or idle timeout is reached, then drains the FIFO to empty.
//
// Ports:
//   clk        in   60 MHz FT2232H comm clock, rising edge
//   reset      in   synchronous active-high reset
//   in_data    in   byte from user logic
//   in_valid   in   in_data is valid
//   in_ready   out  FIFO accepts a byte this cycle
//   out_data   out  head byte to the TX engine
//   out_valid  out  out_data is valid
//   out_ready  in   TX engine takes the head byte
//   count      out  current occupancy (0..DEPTH)
//   full       out  count == DEPTH
//   empty      out  count == 0
// ----------------------------------------------------------------------------
module tx_byte_fifo
  import ft2232h_pkg::*;
#(
  parameter int DEPTH         = DEPTH_DEF,         // power of two, 4..256
  parameter int FLUSH_LEVEL   = FLUSH_LEVEL_DEF,   // 1..DEPTH
  parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF  // >= 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BYTE_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BYTE_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  if ((DEPTH < 4) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (FLUSH_LEVEL < 1) || (FLUSH_LEVEL > DEPTH) || (FLUSH_TIMEOUT < 1)) begin : g_bad_cfg
    $error("tx_byte_fifo: parameter out of range");
  end

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_next;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_en;
  logic              w_rd_en;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // Reset forces the handshake and flags to their idle values combinationally
  // so nothing can be accepted or presented during the reset cycle itself.
  assign in_ready = !reset && !w_full;
  assign full     = !reset && w_full;
  assign empty    = reset || w_empty;
  assign count    = reset ? '0 : r_count;

  // A full FIFO refuses writes even if the head is read on the same edge.
  assign w_wr_en = in_valid && in_ready;
  assign w_rd_en = out_valid && out_ready;

  // Head byte falls straight through from storage.
  assign out_data = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

`ifdef TX_FIFO_FLUSH_EN
  logic w_drain;

  tx_flush_ctrl #(
    .CW            (CW),
    .FLUSH_LEVEL   (FLUSH_LEVEL),
    .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
  ) u_flush_ctrl (
    .clk          (clk),
    .reset        (reset),
    .i_count      (r_count),
    .i_count_next (w_count_next),
    .i_wr_en      (w_wr_en),
    .o_drain      (w_drain)
  );

  assign out_valid = !reset && w_drain && !w_empty;
`else
  assign out_valid = !reset && !w_empty;
`endif

endmodule
